// File: rtl/rc4_ksa_core.sv
// rc4_ksa_core: RC4 identity fill plus key scheduling over an external single-port S memory.
module rc4_ksa_core #(
   parameter int ADDR_W    = 8,
   parameter int KEY_BYTES = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic                   rdy,
   output logic                   done,
   input  logic                   skip_init,
   input  logic [KEY_BYTES*8-1:0] key,
   output logic [ADDR_W-1:0]      addr,
   input  logic [ADDR_W-1:0]      rddata,
   output logic [ADDR_W-1:0]      wrdata,
   output logic                   wren
);
   localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
   typedef enum logic [3:0] {IDLE, INIT, KSA_RI, KSA_LI, KSA_RJ, KSA_LJ, KSA_WI, KSA_WJ, FIN} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, addr_q, wrdata_q, kb;
   logic [KW-1:0] k_q, k_d;
   logic [KEY_BYTES*8-1:0] key_q, key_d;
   logic [7:0] kbyte;
   logic done_q, done_d;
   assign rdy  = state_q == IDLE;
   assign done = done_q;
   // k_q tracks i mod KEY_BYTES so no divider is needed for the key byte select
   always_comb begin
      kbyte   = 8'(key_q >> ((KEY_BYTES - 1 - int'(k_q)) * 8));
      kb      = ADDR_W'(kbyte);
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      k_d     = k_q;
      key_d   = key_q;
      done_d  = 1'b0;
      wren    = 1'b0;
      addr    = addr_q;
      wrdata  = wrdata_q;
      case (state_q)
         IDLE: if (en) begin
            state_d = skip_init ? KSA_RI : INIT;
            key_d   = key;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
         end
         INIT: begin
            addr    = i_q;
            wrdata  = i_q;
            wren    = 1'b1;
            i_d     = i_q + ADDR_W'(1);
            state_d = &i_q ? KSA_RI : INIT;
         end
         KSA_RI: begin
            addr    = i_q;
            state_d = KSA_LI;
         end
         KSA_LI: begin
            si_d    = rddata;
            j_d     = j_q + rddata + kb;
            state_d = KSA_RJ;
         end
         KSA_RJ: begin
            addr    = j_q;
            state_d = KSA_LJ;
         end
         KSA_LJ: begin
            sj_d    = rddata;
            state_d = KSA_WI;
         end
         KSA_WI: begin
            addr    = i_q;
            wrdata  = sj_q;
            wren    = 1'b1;
            state_d = KSA_WJ;
         end
         KSA_WJ: begin
            addr    = j_q;
            wrdata  = si_q;
            wren    = 1'b1;
            i_d     = i_q + ADDR_W'(1);
            k_d     = k_q == KW'(KEY_BYTES - 1) ? '0 : k_q + KW'(1);
            state_d = &i_q ? FIN : KSA_RI;
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         i_q      <= '0;
         j_q      <= '0;
         si_q     <= '0;
         sj_q     <= '0;
         k_q      <= '0;
         key_q    <= '0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         wrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         si_q     <= si_d;
         sj_q     <= sj_d;
         k_q      <= k_d;
         key_q    <= key_d;
         done_q   <= done_d;
         addr_q   <= addr;
         wrdata_q <= wrdata;
      end
   end
endmodule
